// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - packet type codes, scheduler state and defaults for HDMI data islands
package hdmi_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  localparam int PACKET_CYCLES_DEFAULT = 32;

  typedef enum logic {IDLE, BUSY} sched_state_t;

  typedef struct packed {
    logic [7:0] ptype;
    logic [2:0] n;
  } decision_t;

endpackage

// File: rtl/data_island_scheduler.sv
// rtl/data_island_scheduler.sv - picks the packet for each offered data-island slot
// Fixed priority ACR > audio > AVI > audio InfoFrame > null; one packet per PACKET_CYCLES window.
module data_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int PACKET_CYCLES = PACKET_CYCLES_DEFAULT,
  parameter int MAX_SAMPLES   = 4
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       acr_tick,
  input  logic       island_slot,
  input  logic [2:0] audio_avail,
  output logic       pkt_valid,
  output logic [7:0] pkt_type,
  output logic [3:0] sample_present,
  output logic [2:0] audio_pop,
  output logic       acr_overrun,
  output logic       slot_refused
);

  localparam int CW = (PACKET_CYCLES > 2) ? $clog2(PACKET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PACKET_CYCLES - 1);
  localparam logic [2:0]    MAX_N    = 3'(MAX_SAMPLES);

  function automatic decision_t pick(input logic acr, input logic [2:0] avail,
                                     input logic avi, input logic aif);
    decision_t d;
    d.ptype = PKT_NULL;
    d.n     = 3'd0;
    if (acr) begin
      d.ptype = PKT_ACR;
    end else if (avail != 3'd0) begin
      d.ptype = PKT_AUDIO;
      d.n     = (avail > MAX_N) ? MAX_N : avail;
    end else if (avi) begin
      d.ptype = PKT_AVI;
    end else if (aif) begin
      d.ptype = PKT_AIF;
    end
    return d;
  endfunction

  sched_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acr_p_q, acr_p_d, avi_p_q, avi_p_d, aif_p_q, aif_p_d;
  logic [2:0]    avail_q, avail_d;
  logic          valid_q, valid_d, refused_q, refused_d, overrun_q, overrun_d;
  logic [7:0]    type_q, type_d;
  logic [3:0]    present_q, present_d;
  logic [2:0]    pop_q, pop_d;
  logic [4:0]    therm;
  decision_t     dec;
  logic          accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    avail_d   = audio_avail;
    valid_d   = 1'b0;
    type_d    = PKT_NULL;
    present_d = 4'd0;
    pop_d     = 3'd0;
    refused_d = 1'b0;

    dec    = pick(acr_p_q, avail_q, avi_p_q, aif_p_q);
    accept = island_slot && (state_q == IDLE);
    therm  = (5'd1 << dec.n) - 5'd1;

    case (state_q)
      IDLE: begin
        if (island_slot) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        refused_d = island_slot;
        // Leave BUSY as the count hits zero so the next slot lands exactly PACKET_CYCLES later.
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      valid_d   = 1'b1;
      type_d    = dec.ptype;
      pop_d     = dec.n;
      present_d = therm[3:0];
    end

    // A new request in the issuing cycle wins over the clear.
    acr_p_d   = acr_tick    | (acr_p_q & ~(accept && dec.ptype == PKT_ACR));
    avi_p_d   = frame_start | (avi_p_q & ~(accept && dec.ptype == PKT_AVI));
    aif_p_d   = frame_start | (aif_p_q & ~(accept && dec.ptype == PKT_AIF));
    overrun_d = overrun_q | (acr_tick & acr_p_q & ~(accept && dec.ptype == PKT_ACR));
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acr_p_q   <= 1'b0;
      avi_p_q   <= 1'b0;
      aif_p_q   <= 1'b0;
      avail_q   <= 3'd0;
      valid_q   <= 1'b0;
      type_q    <= PKT_NULL;
      present_q <= 4'd0;
      pop_q     <= 3'd0;
      refused_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acr_p_q   <= acr_p_d;
      avi_p_q   <= avi_p_d;
      aif_p_q   <= aif_p_d;
      avail_q   <= avail_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      present_q <= present_d;
      pop_q     <= pop_d;
      refused_q <= refused_d;
      overrun_q <= overrun_d;
    end
  end

  assign pkt_valid      = valid_q;
  assign pkt_type       = type_q;
  assign sample_present = present_q;
  assign audio_pop      = pop_q;
  assign acr_overrun    = overrun_q;
  assign slot_refused   = refused_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb/tb_data_island_scheduler.sv - directed self-checking bench for data_island_scheduler
module tb_data_island_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       acr_tick = 1'b0;
  logic       island_slot = 1'b0;
  logic [2:0] audio_avail = 3'd0;
  logic       pkt_valid;
  logic [7:0] pkt_type;
  logic [3:0] sample_present;
  logic [2:0] audio_pop;
  logic       acr_overrun;
  logic       slot_refused;

  int checks = 0;
  int errors = 0;

  data_island_scheduler dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .frame_start    (frame_start),
    .acr_tick       (acr_tick),
    .island_slot    (island_slot),
    .audio_avail    (audio_avail),
    .pkt_valid      (pkt_valid),
    .pkt_type       (pkt_type),
    .sample_present (sample_present),
    .audio_pop      (audio_pop),
    .acr_overrun    (acr_overrun),
    .slot_refused   (slot_refused)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer();
    island_slot = 1'b1;
    tick();
    island_slot = 1'b0;
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] t, input logic [3:0] sp,
                           input logic [2:0] pop);
    check({tag, ".valid"}, 32'(pkt_valid), 32'd1);
    check({tag, ".type"}, 32'(pkt_type), 32'(t));
    check({tag, ".present"}, 32'(sample_present), 32'(sp));
    check({tag, ".pop"}, 32'(audio_pop), 32'(pop));
  endtask

  task automatic pulse_acr();
    acr_tick = 1'b1;
    tick();
    acr_tick = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    idle(3);
    check("rst.valid", 32'(pkt_valid), 32'd0);
    check("rst.type", 32'(pkt_type), 32'h00);
    check("rst.present", 32'(sample_present), 32'd0);
    check("rst.pop", 32'(audio_pop), 32'd0);
    check("rst.overrun", 32'(acr_overrun), 32'd0);
    check("rst.refused", 32'(slot_refused), 32'd0);
    reset = 1'b0;
    idle(2);

    // Null packet with nothing pending
    offer();
    check_pkt("null0", 8'h00, 4'h0, 3'd0);
    tick();
    check("null0.pulse", 32'(pkt_valid), 32'd0);
    idle(40);

    // ACR, two audio packets, AVI, AIF, then null
    pulse_acr();
    pulse_frame();
    audio_avail = 3'd5;
    idle(2);
    offer();
    check_pkt("seq.acr", 8'h01, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("seq.aud4", 8'h02, 4'hF, 3'd4);
    audio_avail = 3'd1;
    idle(31);
    offer();
    check_pkt("seq.aud1", 8'h02, 4'h1, 3'd1);
    audio_avail = 3'd0;
    idle(31);
    offer();
    check_pkt("seq.avi", 8'h82, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("seq.aif", 8'h84, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("seq.null", 8'h00, 4'h0, 3'd0);
    idle(40);

    // Refused slots inside the packet window; t+32 accepted
    offer();
    check_pkt("ref.first", 8'h00, 4'h0, 3'd0);
    idle(9);
    offer();
    check("ref.t10.refused", 32'(slot_refused), 32'd1);
    check("ref.t10.valid", 32'(pkt_valid), 32'd0);
    tick();
    check("ref.t10.pulse", 32'(slot_refused), 32'd0);
    idle(19);
    offer();
    check("ref.t31.refused", 32'(slot_refused), 32'd1);
    check("ref.t31.valid", 32'(pkt_valid), 32'd0);
    offer();
    check("ref.t32.valid", 32'(pkt_valid), 32'd1);
    check("ref.t32.refused", 32'(slot_refused), 32'd0);
    idle(40);

    // ACR overrun, single ACR issued
    pulse_acr();
    check("ovr.first", 32'(acr_overrun), 32'd0);
    tick();
    pulse_acr();
    check("ovr.set", 32'(acr_overrun), 32'd1);
    idle(2);
    offer();
    check_pkt("ovr.acr", 8'h01, 4'h0, 3'd0);
    idle(40);
    offer();
    check_pkt("ovr.once", 8'h00, 4'h0, 3'd0);
    check("ovr.sticky", 32'(acr_overrun), 32'd1);
    idle(40);

    // acr_tick coincident with accepted slot is served next slot
    audio_avail = 3'd2;
    idle(2);
    acr_tick = 1'b1;
    island_slot = 1'b1;
    tick();
    acr_tick = 1'b0;
    island_slot = 1'b0;
    check_pkt("same.aud2", 8'h02, 4'h3, 3'd2);
    audio_avail = 3'd0;
    idle(31);
    offer();
    check_pkt("same.acr", 8'h01, 4'h0, 3'd0);
    idle(40);

    // frame_start re-set while AVI issues: set wins
    pulse_frame();
    idle(2);
    frame_start = 1'b1;
    island_slot = 1'b1;
    tick();
    frame_start = 1'b0;
    island_slot = 1'b0;
    check_pkt("setwin.avi1", 8'h82, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("setwin.avi2", 8'h82, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("setwin.aif", 8'h84, 4'h0, 3'd0);
    idle(31);
    offer();
    check_pkt("setwin.aif_once", 8'h00, 4'h0, 3'd0);
    idle(40);

    // Reset mid-packet drops pending AVI/AIF and frees the slot
    acr_tick = 1'b1;
    frame_start = 1'b1;
    tick();
    acr_tick = 1'b0;
    frame_start = 1'b0;
    idle(2);
    offer();
    check_pkt("rstmid.acr", 8'h01, 4'h0, 3'd0);
    idle(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.valid", 32'(pkt_valid), 32'd0);
    check("rstmid.overrun", 32'(acr_overrun), 32'd0);
    tick();
    offer();
    check_pkt("rstmid.null", 8'h00, 4'h0, 3'd0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
